pipelined_adder: RTL and testbench

Parametrised, pipelined successor to the team's 4-bit ripple-carry adder. It splits a WIDTH-bit add/subtract into WIDTH/CHUNK ripple slices, one register stage per slice, and sustains one operation per clock. A valid/ready handshake on both sides provides back-pressure, and the output adds signed overflow and a subtract mode. It sits between operand producers (register file, generator) and result consumers in the datapath.

---
 rtl/adder_pkg.sv | 21 ++
 rtl/adder_slice.sv | 30 +++
 rtl/pipelined_adder.sv | 106 ++++++++++
 tb/tb_pipelined_adder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants, stage-count helper and stage record for the pipelined adder
package adder_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CHUNK = 4;

    function automatic int stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Operands travel full width so every stage indexes its own chunk directly.
    typedef struct packed {
        logic                 valid;
        logic                 carry;
        logic                 c_msb;
        logic [DEF_WIDTH-1:0] sum;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } stage_rec_t;

endpackage

// File: rtl/adder_slice.sv
// rtl/adder_slice.sv - combinational CHUNK-bit ripple-carry slice
module adder_slice
    import adder_pkg::*;
#(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit add/subtract split into CHUNK-bit register stages with valid/ready
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = stages(WIDTH, CHUNK);

    if ((WIDTH % CHUNK) != 0 || STAGES < 1) begin : g_bad_cfg
        $fatal(1, "pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
    end

    typedef struct packed {
        logic             valid;
        logic             carry;
        logic             c_msb;
        logic [WIDTH-1:0] sum;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } stage_t;

    stage_t in_rec;
    stage_t pipe_d [STAGES];
    stage_t pipe_q [STAGES];
    logic   adv;

    // The whole pipe moves in lockstep; only the output register can stall it.
    assign adv      = !pipe_q[STAGES-1].valid || out_ready;
    assign in_ready = adv;

    always_comb begin
        in_rec       = '0;
        in_rec.valid = in_valid;
        in_rec.a     = a;
        in_rec.b     = sub ? ~b : b;
        in_rec.carry = sub ? 1'b1 : cin;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src;
        stage_t           nxt;
        logic [CHUNK-1:0] s;
        logic             co;
        logic             c_msb;

        if (k == 0) begin : g_first
            assign src = in_rec;
        end else begin : g_next
            assign src = pipe_q[k-1];
        end

        adder_slice #(
            .CHUNK(CHUNK)
        ) u_slice (
            .a    (src.a[k*CHUNK +: CHUNK]),
            .b    (src.b[k*CHUNK +: CHUNK]),
            .ci   (src.carry),
            .s    (s),
            .co   (co),
            .c_msb(c_msb)
        );

        always_comb begin
            nxt                       = src;
            nxt.sum[k*CHUNK +: CHUNK] = s;
            nxt.carry                 = co;
            nxt.c_msb                 = c_msb;
        end

        assign pipe_d[k] = nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe_q[i] <= '0;
            end
        end else if (adv) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
        end
    end

    assign out_valid = pipe_q[STAGES-1].valid;
    assign sum       = pipe_q[STAGES-1].sum;
    assign cout      = pipe_q[STAGES-1].carry;
    assign ovf       = pipe_q[STAGES-1].carry ^ pipe_q[STAGES-1].c_msb;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - directed and reference-model checks for pipelined_adder (16/4 and 8/8)
module tb_pipelined_adder;

    localparam int NBEATS  = 10000;
    localparam int RND_MAX = 60000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid16, in_ready16, cin16, sub16, out_valid16, out_ready16, cout16, ovf16;
    logic [15:0] a16, b16, sum16;
    logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
    logic [7:0]  a8, b8, sum8;

    int n_checks = 0;
    int n_errors = 0;

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .cin(cin16), .sub(sub16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .sub(sub8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat16(input logic [15:0] x, input logic [15:0] y, input logic c, input logic s);
        in_valid16 = 1'b1;
        a16 = x;
        b16 = y;
        cin16 = c;
        sub16 = s;
    endtask

    // Reference result: {ovf, cout, sum}, overflow from operand/result signs.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                            input logic c, input logic s);
        logic [15:0] yy;
        logic [16:0] f;
        logic        o;
        yy = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, yy} + {16'd0, (s ? 1'b1 : c)};
        o  = (x[15] == yy[15]) && (f[15] != x[15]);
        return {o, f[16], f[15:0]};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y,
                                          input logic c, input logic s);
        logic [7:0] yy;
        logic [8:0] f;
        logic       o;
        yy = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, yy} + {8'd0, (s ? 1'b1 : c)};
        o  = (x[7] == yy[7]) && (f[7] != x[7]);
        return {o, f[8], f[7:0]};
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  mv;
        logic        madv, prev_stall, seen, pend16, pend8;
        logic [15:0] prev_sum;
        logic [17:0] q16[$];
        logic [9:0]  q8[$];
        logic [17:0] e16;
        logic [9:0]  e8;
        logic        pat[4];
        int          in_idx, out_cnt, cyc, sent16, sent8, got16, got8;

        rst = 1'b1;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; out_ready16 = 1'b1;
        in_valid8  = 1'b0; a8  = '0; b8  = '0; cin8  = 1'b0; sub8  = 1'b0; out_ready8  = 1'b1;
        step();
        step();
        check("rst_out_valid", 32'(out_valid16), 32'd0);
        check("rst_sum", 32'(sum16), 32'd0);
        check("rst_cout_ovf", 32'({cout16, ovf16}), 32'd0);
        check("rst_in_ready", 32'(in_ready16), 32'd1);
        check("rst_out_valid8", 32'(out_valid8), 32'd0);
        rst = 1'b0;
        step();

        beat16(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        step();
        in_valid16 = 1'b0;
        check("lat_edge0", 32'(out_valid16), 32'd0);
        step();
        step();
        check("lat_edge2", 32'(out_valid16), 32'd0);
        step();
        check("wrap_valid", 32'(out_valid16), 32'd1);
        check("wrap_res", 32'({ovf16, cout16, sum16}), 32'h1_0000);
        step();
        check("wrap_no_dup", 32'(out_valid16), 32'd0);

        beat16(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        step();
        beat16(16'h0005, 16'h0007, 1'b0, 1'b1);
        step();
        in_valid16 = 1'b0;
        step();
        step();
        check("b2b_ovf_valid", 32'(out_valid16), 32'd1);
        check("b2b_ovf_res", 32'({ovf16, cout16, sum16}), 32'h2_8000);
        step();
        check("b2b_sub_valid", 32'(out_valid16), 32'd1);
        check("b2b_sub_res", 32'({ovf16, cout16, sum16}), 32'h0_FFFE);
        step();
        check("b2b_drained", 32'(out_valid16), 32'd0);

        beat16(16'h0003, 16'h0003, 1'b1, 1'b1);
        step();
        beat16(16'h0003, 16'h0003, 1'b1, 1'b0);
        step();
        in_valid16 = 1'b0;
        step();
        step();
        check("sub_cin_ignored", 32'({ovf16, cout16, sum16}), 32'h1_0000);
        step();
        check("add_cin_used", 32'({ovf16, cout16, sum16}), 32'h0_0007);
        step();

        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        mv = '0;
        in_idx = 0;
        out_cnt = 0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_sum = '0;
        cin16 = 1'b0;
        sub16 = 1'b0;
        while ((in_idx < 8 || out_cnt < 8) && cyc < 200) begin
            out_ready16 = pat[cyc % 4];
            in_valid16 = (in_idx < 8);
            a16 = 16'(in_idx);
            b16 = 16'(in_idx << 8);
            #1;
            madv = !mv[3] || out_ready16;
            check("stream_in_ready", 32'(in_ready16), 32'(madv));
            check("stream_out_valid", 32'(out_valid16), 32'(mv[3]));
            if (prev_stall) begin
                check("stall_hold_sum", 32'(sum16), 32'(prev_sum));
            end
            prev_stall = out_valid16 && !out_ready16;
            prev_sum = sum16;
            if (out_valid16 && out_ready16) begin
                check("stream_sum", 32'(sum16), 32'(16'(out_cnt * 16'h0101)));
                out_cnt++;
            end
            if (in_valid16 && in_ready16) in_idx++;
            if (madv) mv = {mv[2:0], in_valid16};
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        check("stream_bound", 32'(cyc < 200), 32'd1);
        check("stream_count", 32'(out_cnt), 32'd8);
        step();
        check("stream_no_extra", 32'(out_valid16), 32'd0);

        out_ready16 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            beat16(16'(16'h1111 * (i + 1)), 16'h0001, 1'b0, 1'b0);
            step();
        end
        in_valid16 = 1'b0;
        check("rstmid_stalled", 32'({out_valid16, in_ready16, sum16}), 32'h2_1112);
        #2;
        rst = 1'b1;
        #1;
        check("rstmid_out_valid", 32'(out_valid16), 32'd0);
        check("rstmid_sum", 32'({cout16, ovf16, sum16}), 32'd0);
        step();
        rst = 1'b0;
        out_ready16 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid16) seen = 1'b1;
        end
        check("rstmid_no_stale", 32'(seen), 32'd0);
        check("rstmid_in_ready", 32'(in_ready16), 32'd1);

        in_valid8 = 1'b1;
        a8 = 8'h80;
        b8 = 8'h80;
        step();
        in_valid8 = 1'b0;
        check("w8_valid", 32'(out_valid8), 32'd1);
        check("w8_res", 32'({ovf8, cout8, sum8}), 32'h300);
        step();
        check("w8_no_dup", 32'(out_valid8), 32'd0);

        sent16 = 0; sent8 = 0; got16 = 0; got8 = 0; cyc = 0;
        pend16 = 1'b0; pend8 = 1'b0;
        while ((got16 < NBEATS || got8 < NBEATS) && cyc < RND_MAX) begin
            out_ready16 = ($urandom_range(3) != 0);
            out_ready8  = ($urandom_range(3) != 0);
            if (!pend16) begin
                in_valid16 = (sent16 < NBEATS) && ($urandom_range(4) != 0);
                a16 = 16'($urandom); b16 = 16'($urandom);
                cin16 = 1'($urandom_range(1)); sub16 = 1'($urandom_range(1));
                pend16 = in_valid16;
            end
            if (!pend8) begin
                in_valid8 = (sent8 < NBEATS) && ($urandom_range(4) != 0);
                a8 = 8'($urandom); b8 = 8'($urandom);
                cin8 = 1'($urandom_range(1)); sub8 = 1'($urandom_range(1));
                pend8 = in_valid8;
            end
            #1;
            if (out_valid16 && out_ready16) begin
                if (q16.size() == 0) begin
                    check("rnd16_spurious", 32'd1, 32'd0);
                end else begin
                    e16 = q16.pop_front();
                    check("rnd16", 32'({ovf16, cout16, sum16}), 32'(e16));
                end
                got16++;
            end
            if (out_valid8 && out_ready8) begin
                if (q8.size() == 0) begin
                    check("rnd8_spurious", 32'd1, 32'd0);
                end else begin
                    e8 = q8.pop_front();
                    check("rnd8", 32'({ovf8, cout8, sum8}), 32'(e8));
                end
                got8++;
            end
            if (in_valid16 && in_ready16) begin
                q16.push_back(model16(a16, b16, cin16, sub16));
                sent16++;
                pend16 = 1'b0;
            end
            if (in_valid8 && in_ready8) begin
                q8.push_back(model8(a8, b8, cin8, sub8));
                sent8++;
                pend8 = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!pend16) in_valid16 = 1'b0;
            if (!pend8) in_valid8 = 1'b0;
            cyc++;
        end
        check("rnd_bound", 32'(cyc < RND_MAX), 32'd1);
        check("rnd_drained", 32'(q16.size() + q8.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
